vga_scaled_timing_ctrl: RTL and testbench
=========================================

Name: vga_scaled_timing_ctrl

Overview:
Parametrised VGA timing generator with integer pixel replication by 2^SCALE_SHIFT. It reads a reduced-resolution frame buffer (BRAM) and drives the VGA pins. Sync, DE and colour outputs are delayed to compensate for a configurable frame-buffer read latency. It is the next-generation replacement for the fixed 640x480 controller and sits between the frame buffer read port and the VGA connector.

Parameters:
H_ACTIVE 640 visible pixels per line
H_FP 16 horizontal front porch (clocks)
H_SYNC 96 horizontal sync width (clocks)
H_BP 48 horizontal back porch (clocks)
V_ACTIVE 480 visible lines
V_FP 10 vertical front porch (lines)
V_SYNC 2 vertical sync width (lines)
V_BP 33 vertical back porch (lines)
HSYNC_POL 0 active level of HSYNC_O (0 = active low)
VSYNC_POL 0 active level of VSYNC_O
SCALE_SHIFT 1 replication factor 2^SCALE_SHIFT in x and y (0..2)
COLOR_W 4 bits per colour channel
ADDR_W 17 frame-buffer address width
RD_LATENCY 1 clocks from ADDRESS_O to valid VIDEO_PXL_I (1..4)

Ports:
CLK_I input 1 pixel clock
RST_I input 1 synchronous reset, active high
ENABLE_I input 1 run request (level)
VIDEO_PXL_I input 3*COLOR_W pixel {R,G,B}, valid RD_LATENCY clocks after ADDRESS_O
ADDRESS_O output ADDR_W frame-buffer read address
RD_EN_O output 1 read strobe qualifying ADDRESS_O
RED_O output COLOR_W red
GREEN_O output COLOR_W green
BLUE_O output COLOR_W blue
HSYNC_O output 1 horizontal sync
VSYNC_O output 1 vertical sync
VIDEO_EN_O output 1 display enable
FRAME_START_O output 1 one-clock pulse aligned with the first active pixel of each frame
BUSY_O output 1 high while not IDLE

Behaviour:
- Reset is synchronous, active high. Reset values:
  - state IDLE; counters 0.
  - ADDRESS_O 0; RD_EN_O, VIDEO_EN_O, FRAME_START_O, BUSY_O 0; RGB 0.
  - HSYNC_O = ~HSYNC_POL; VSYNC_O = ~VSYNC_POL.
- Counters:
  - h_cnt runs 0..H_TOT-1, H_TOT = sum of H_*; v_cnt runs 0..V_TOT-1; both $clog2-sized.
  - h region order: active [0,H_ACTIVE), then FP, SYNC, BP. v uses the same order.
  - Default sync windows: h 656..751, v 490..491.
  - v_cnt advances when h_cnt wraps.
- State machine:
  - IDLE -> RUN on the rising edge of ENABLE_I (registered previous value 0, current 1). Counters start at (0,0) on the next clock.
  - RUN -> STOP when ENABLE_I is low.
  - STOP -> RUN if ENABLE_I returns high before the frame ends, with no restart and no counter disturbance.
  - STOP -> IDLE at h=H_TOT-1, v=V_TOT-1. The current frame always completes; no truncated frames.
  - IDLE: outputs held at reset values, counters held at 0.
- Stage 0 (timing): RD_EN_O = 1 when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE in RUN/STOP. ADDRESS_O is registered, with a combinational RD_EN_O qualifier from the same counter state.
- Address generation, incremental with no multiplier:
  - Address = line_base + col.
  - col increments every 2^S active pixels (sub-counter px_rep) and resets to 0 at line start.
  - At end of each active line, ln_rep increments. When ln_rep wraps (2^S lines), line_base += H_ACTIVE>>S.
  - line_base = 0 at frame start.
  - Max address = (H_ACTIVE>>S)*(V_ACTIVE>>S)-1; the default is 76799.
  - H_ACTIVE and V_ACTIVE must be divisible by 2^S. ADDR_W must hold the max address.
  - ADDRESS_O holds its last value outside active.
- Output alignment:
  - HSYNC/VSYNC/DE/FRAME_START decode from stage 0. They pass through a shift register of RD_LATENCY stages, then one output register.
  - RGB is registered at the same final stage as DE_d ? VIDEO_PXL_I : 0.
  - All pin outputs are therefore RD_LATENCY+1 clocks after the matching RD_EN_O/ADDRESS_O.
- Sync polarity: active = *_POL, inactive = ~*_POL.
- Reset mid-frame: all outputs return to reset values on the next clock, including the delay-pipeline contents. A new ENABLE_I rising edge is required to restart; a level held high through reset is not a rising edge.
- ENABLE_I toggling during RUN only affects the stop decision. No extra FRAME_START_O pulses.

Test Plan:
1. Reset, then RST_I=0 with ENABLE_I=0 for 100 clocks -> HSYNC_O=VSYNC_O=1, all others 0, BUSY_O=0.
2. Defaults, ENABLE_I rising edge -> HSYNC_O period 800 and low for 96 clocks. VSYNC_O period 420000 clocks and low for 2 lines. VIDEO_EN_O high 640 clocks per line for 480 lines. One FRAME_START_O per frame, coincident with the first VIDEO_EN_O.
3. Address check, S=1 -> line 0 RD_EN addresses 0,0,1,1,...,319,319; line 1 identical; line 2 starts at 320. Last address of the frame is 76799, and the next frame starts at 0.
4. RD_LATENCY=3, BRAM model returning data=address -> VIDEO_EN_O rises exactly 4 clocks after the first RD_EN_O. RED/GREEN/BLUE match the model for every active pixel and are 0 in blanking.
5. ENABLE_I low during line 100 -> BUSY_O stays high until after h=799, v=524. Then IDLE with no truncated frame. ENABLE_I high during STOP continues seamlessly.
6. Reset asserted at line 200, then released with ENABLE_I held high -> outputs at reset values and no restart. ENABLE_I 0->1 starts again at (0,0). Repeat with HSYNC_POL=1, SCALE_SHIFT=0, ADDR_W=19 -> HSYNC_O active high, linear addresses 0..307199.

Source files
------------

// File: rtl/vga_scaled_timing_ctrl.sv
// VGA timing generator with 2^SCALE_SHIFT pixel replication over a reduced-resolution frame buffer.
// Sync/DE/colour are delayed RD_LATENCY+1 clocks behind the frame-buffer read address.
module vga_scaled_timing_ctrl #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned HSYNC_POL   = 0,
    parameter int unsigned VSYNC_POL   = 0,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 ENABLE_I,
    input  logic [3*COLOR_W-1:0] VIDEO_PXL_I,
    output logic [ADDR_W-1:0]    ADDRESS_O,
    output logic                 RD_EN_O,
    output logic [COLOR_W-1:0]   RED_O,
    output logic [COLOR_W-1:0]   GREEN_O,
    output logic [COLOR_W-1:0]   BLUE_O,
    output logic                 HSYNC_O,
    output logic                 VSYNC_O,
    output logic                 VIDEO_EN_O,
    output logic                 FRAME_START_O,
    output logic                 BUSY_O
);
    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);
    localparam int unsigned REP_W = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic              HS_ON     = 1'(HSYNC_POL);
    localparam logic              VS_ON     = 1'(VSYNC_POL);
    localparam logic [3:0]        PIPE_IDLE = {~HS_ON, ~VS_ON, 2'b00};

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t                state, state_next;
    logic                  enable_q;
    logic [HW-1:0]         h_cnt, h_next;
    logic [VW-1:0]         v_cnt, v_next;
    logic [REP_W-1:0]      px_rep, px_rep_next, ln_rep, ln_rep_next;
    logic [ADDR_W-1:0]     col, col_next, line_base, line_base_next, addr_next;
    logic                  h_end, frame_end, active;
    logic                  hs0, vs0, fs0;
    logic [3:0]            pipe [RD_LATENCY];
    logic [3*COLOR_W-1:0]  rgb;

    assign h_end     = (h_cnt == H_LAST);
    assign frame_end = h_end && (v_cnt == V_LAST);
    assign active    = (state != IDLE) && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign RD_EN_O   = active;
    assign BUSY_O    = (state != IDLE);

    // Sampled through reset too, so a level held high across reset never looks like a rising edge.
    always_ff @(posedge CLK_I) begin
        enable_q <= ENABLE_I;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) state <= IDLE;
        else       state <= state_next;
    end

    // Dropping ENABLE_I on the very last clock of a frame goes straight to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ENABLE_I && !enable_q) state_next = RUN;
            RUN:     if (!ENABLE_I) state_next = frame_end ? IDLE : STOP;
            STOP: begin
                if (ENABLE_I)       state_next = RUN;
                else if (frame_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        h_next         = '0;
        v_next         = '0;
        px_rep_next    = '0;
        ln_rep_next    = '0;
        col_next       = '0;
        line_base_next = '0;
        addr_next      = '0;
        if (state != IDLE && state_next != IDLE) begin
            h_next         = h_end ? '0 : h_cnt + 1'b1;
            v_next         = !h_end ? v_cnt : ((v_cnt == V_LAST) ? '0 : v_cnt + 1'b1);
            px_rep_next    = px_rep;
            ln_rep_next    = ln_rep;
            col_next       = col;
            line_base_next = line_base;
            addr_next      = ADDRESS_O;
            if (active) begin
                if (h_cnt == H_ACT_LAST) begin
                    px_rep_next = '0;
                    col_next    = '0;
                    ln_rep_next = ln_rep + 1'b1;
                    if (ln_rep == REP_LAST) begin
                        ln_rep_next    = '0;
                        line_base_next = line_base + LINE_STEP;
                    end
                end else if (px_rep == REP_LAST) begin
                    px_rep_next = '0;
                    col_next    = col + 1'b1;
                end else begin
                    px_rep_next = px_rep + 1'b1;
                end
            end
            if (frame_end) begin
                line_base_next = '0;
                ln_rep_next    = '0;
            end
            // Address is precomputed one clock ahead so it lines up with the combinational RD_EN_O.
            if (h_next < H_ACT && v_next < V_ACT) addr_next = line_base_next + col_next;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            px_rep    <= '0;
            ln_rep    <= '0;
            col       <= '0;
            line_base <= '0;
            ADDRESS_O <= '0;
        end else begin
            h_cnt     <= h_next;
            v_cnt     <= v_next;
            px_rep    <= px_rep_next;
            ln_rep    <= ln_rep_next;
            col       <= col_next;
            line_base <= line_base_next;
            ADDRESS_O <= addr_next;
        end
    end

    always_comb begin
        hs0 = ~HS_ON;
        vs0 = ~VS_ON;
        if (state != IDLE && h_cnt >= HS_BEG && h_cnt <= HS_LAST) hs0 = HS_ON;
        if (state != IDLE && v_cnt >= VS_BEG && v_cnt <= VS_LAST) vs0 = VS_ON;
        fs0 = active && (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) pipe[i] <= PIPE_IDLE;
            {HSYNC_O, VSYNC_O, VIDEO_EN_O, FRAME_START_O} <= PIPE_IDLE;
            rgb <= '0;
        end else begin
            pipe[0] <= {hs0, vs0, active, fs0};
            for (int unsigned i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
            {HSYNC_O, VSYNC_O, VIDEO_EN_O, FRAME_START_O} <= pipe[RD_LATENCY-1];
            rgb <= pipe[RD_LATENCY-1][1] ? VIDEO_PXL_I : '0;
        end
    end

    assign {RED_O, GREEN_O, BLUE_O} = rgb;

endmodule

// File: tb/tb_vga_scaled_timing_ctrl.sv
// Bench for vga_scaled_timing_ctrl: two reduced-timing instances (scaled/latency 3, linear/latency 1)
// driven with directed and random enable/reset sequences, checked against a frame-position model.
module tb_vga_scaled_timing_ctrl;
    localparam int T_HA = 16, T_HFP = 2, T_HSY = 3, T_HBP = 3;
    localparam int T_VA = 8,  T_VFP = 1, T_VSY = 2, T_VBP = 1;
    localparam int HT = T_HA + T_HFP + T_HSY + T_HBP;
    localparam int VT = T_VA + T_VFP + T_VSY + T_VBP;
    localparam int FRAME = HT * VT;
    localparam int AW = 8, CW = 4;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic          fs;
        logic [AW-1:0] addr;
    } rec_t;

    logic clk = 1'b0;
    logic rst, en;
    logic [3*CW-1:0] pxl_a, pxl_b;
    logic [AW-1:0]   addr_a, addr_b;
    logic            rd_a, rd_b, hs_a, hs_b, vs_a, vs_b, de_a, de_b, fs_a, fs_b, busy_a, busy_b;
    logic [CW-1:0]   r_a, g_a, b_a, r_b, g_b, b_b;

    always #5 clk = ~clk;

    // Frame-buffer model: registered reads, data = mem[address] RD_LATENCY clocks later.
    logic [3*CW-1:0] mem [256];
    logic [AW-1:0]   apipe_a [3];
    logic [AW-1:0]   apipe_b;
    always @(posedge clk) begin
        apipe_a[0] <= addr_a;
        apipe_a[1] <= apipe_a[0];
        apipe_a[2] <= apipe_a[1];
        apipe_b    <= addr_b;
    end
    assign pxl_a = mem[apipe_a[2]];
    assign pxl_b = mem[apipe_b];

    vga_scaled_timing_ctrl #(
        .H_ACTIVE(T_HA), .H_FP(T_HFP), .H_SYNC(T_HSY), .H_BP(T_HBP),
        .V_ACTIVE(T_VA), .V_FP(T_VFP), .V_SYNC(T_VSY), .V_BP(T_VBP),
        .HSYNC_POL(0), .VSYNC_POL(0), .SCALE_SHIFT(1), .COLOR_W(CW),
        .ADDR_W(AW), .RD_LATENCY(3)
    ) dut_a (
        .CLK_I(clk), .RST_I(rst), .ENABLE_I(en), .VIDEO_PXL_I(pxl_a),
        .ADDRESS_O(addr_a), .RD_EN_O(rd_a), .RED_O(r_a), .GREEN_O(g_a), .BLUE_O(b_a),
        .HSYNC_O(hs_a), .VSYNC_O(vs_a), .VIDEO_EN_O(de_a), .FRAME_START_O(fs_a), .BUSY_O(busy_a)
    );

    vga_scaled_timing_ctrl #(
        .H_ACTIVE(T_HA), .H_FP(T_HFP), .H_SYNC(T_HSY), .H_BP(T_HBP),
        .V_ACTIVE(T_VA), .V_FP(T_VFP), .V_SYNC(T_VSY), .V_BP(T_VBP),
        .HSYNC_POL(1), .VSYNC_POL(0), .SCALE_SHIFT(0), .COLOR_W(CW),
        .ADDR_W(AW), .RD_LATENCY(1)
    ) dut_b (
        .CLK_I(clk), .RST_I(rst), .ENABLE_I(en), .VIDEO_PXL_I(pxl_b),
        .ADDRESS_O(addr_b), .RD_EN_O(rd_b), .RED_O(r_b), .GREEN_O(g_b), .BLUE_O(b_b),
        .HSYNC_O(hs_b), .VSYNC_O(vs_b), .VIDEO_EN_O(de_b), .FRAME_START_O(fs_b), .BUSY_O(busy_b)
    );

    // Reference model: running flag plus linear position k within the frame.
    bit            running, en_prev;
    int            k;
    int            n_vec, n_err;
    rec_t          qa[$], qb[$];
    logic [AW-1:0] ea_addr, eb_addr;

    function automatic rec_t stage0(int s, bit hpol, bit vpol, logic [AW-1:0] prev_addr);
        int   h, v;
        rec_t r;
        h = k % HT;
        v = k / HT;
        r.hs = (running && h >= T_HA + T_HFP && h < T_HA + T_HFP + T_HSY) ? hpol : !hpol;
        r.vs = (running && v >= T_VA + T_VFP && v < T_VA + T_VFP + T_VSY) ? vpol : !vpol;
        r.de = running && h < T_HA && v < T_VA;
        r.fs = r.de && (k == 0);
        if (r.de)         r.addr = AW'((v >> s) * (T_HA >> s) + (h >> s));
        else if (running) r.addr = prev_addr;
        else              r.addr = '0;
        return r;
    endfunction

    task automatic reset_q();
        rec_t ia, ib;
        ia = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, addr: '0};
        ib = '{hs: 1'b0, vs: 1'b1, de: 1'b0, fs: 1'b0, addr: '0};
        qa.delete();
        qb.delete();
        repeat (4) qa.push_back(ia);
        repeat (2) qb.push_back(ib);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (k=%0d running=%0d)", tag, obs, exp, k, running);
        end
    endtask

    // Check the current cycle at the falling edge, then set inputs for the next rising edge.
    task automatic step(bit new_rst, bit new_en);
        rec_t ra, rb, pa, pb;
        @(negedge clk);
        ra = stage0(1, 1'b0, 1'b0, ea_addr);
        rb = stage0(0, 1'b1, 1'b0, eb_addr);
        ea_addr = ra.addr;
        eb_addr = rb.addr;
        pa = qa.pop_front();
        pb = qb.pop_front();
        chk("a_rd_en", 32'(rd_a), 32'(ra.de));
        chk("a_addr",  32'(addr_a), 32'(ra.addr));
        chk("a_busy",  32'(busy_a), 32'(running));
        chk("a_hsync", 32'(hs_a), 32'(pa.hs));
        chk("a_vsync", 32'(vs_a), 32'(pa.vs));
        chk("a_de",    32'(de_a), 32'(pa.de));
        chk("a_fs",    32'(fs_a), 32'(pa.fs));
        chk("a_rgb",   32'({r_a, g_a, b_a}), pa.de ? 32'(mem[pa.addr]) : 32'd0);
        chk("b_rd_en", 32'(rd_b), 32'(rb.de));
        chk("b_addr",  32'(addr_b), 32'(rb.addr));
        chk("b_busy",  32'(busy_b), 32'(running));
        chk("b_hsync", 32'(hs_b), 32'(pb.hs));
        chk("b_vsync", 32'(vs_b), 32'(pb.vs));
        chk("b_de",    32'(de_b), 32'(pb.de));
        chk("b_fs",    32'(fs_b), 32'(pb.fs));
        chk("b_rgb",   32'({r_b, g_b, b_b}), pb.de ? 32'(mem[pb.addr]) : 32'd0);
        qa.push_back(ra);
        qb.push_back(rb);

        rst = new_rst;
        en  = new_en;
        if (new_rst) begin
            running = 1'b0;
            k       = 0;
            ea_addr = '0;
            eb_addr = '0;
            reset_q();
        end else if (!running) begin
            if (new_en && !en_prev) begin
                running = 1'b1;
                k       = 0;
            end
        end else if (k == FRAME - 1 && !new_en) begin
            running = 1'b0;
            k       = 0;
        end else begin
            k = (k + 1) % FRAME;
        end
        en_prev = new_en;
    endtask

    initial begin
        bit e;
        rst = 1'b1;
        en = 1'b0;
        n_vec = 0;
        n_err = 0;
        running = 1'b0;
        en_prev = 1'b0;
        k = 0;
        ea_addr = '0;
        eb_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
        reset_q();
        repeat (5) @(posedge clk);

        // Idle after reset.
        repeat (100) step(0, 0);

        // Start and run over two full frames.
        repeat (2 * FRAME + $urandom_range(0, 40)) step(0, 1);

        // Stop during line 3, resume before frame end, then stop for good.
        for (int i = 0; i < FRAME && !(running && k / HT == 3 && k % HT == 5); i++) step(0, 1);
        repeat ($urandom_range(5, 60)) step(0, 0);
        repeat (30) step(0, 1);
        for (int i = 0; i < 2 * FRAME && running; i++) step(0, 0);
        repeat (20) step(0, 0);

        // Reset mid-frame with enable held high, then a fresh rising edge.
        step(0, 1);
        repeat (5 * HT + $urandom_range(0, HT - 1)) step(0, 1);
        repeat (2) step(1, 1);
        repeat (50) step(0, 1);
        step(0, 0);
        step(0, 1);
        repeat (FRAME + FRAME / 2) step(0, 1);

        // Random enable toggling.
        e = 1'b1;
        repeat (800) begin
            if ($urandom_range(0, 19) == 0) e = ~e;
            step(0, e);
        end

        // Drain to idle.
        for (int i = 0; i < 2 * FRAME + 8 && running; i++) step(0, 0);
        repeat (8) step(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
